// File: rtl/icache_nway_burst_pkg.sv
// Shared types and constants for the N-way burst instruction cache.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package icache_nway_burst_pkg;

    // Refill controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_e;

    // Fixed AXI read burst attributes: incrementing bursts of 32-bit words.
    localparam logic [1:0] ARBURST_INCR = 2'b01;
    localparam logic [2:0] ARSIZE_WORD  = 3'b010;

    // Width of a way selector; a direct-mapped cache still keeps one bit.
    function automatic int way_bits(input int way_num);
        return (way_num > 1) ? $clog2(way_num) : 1;
    endfunction

endpackage

// File: rtl/icache_nway_burst_if.sv
// CPU fetch port plus AXI-like burst read channel of the instruction cache.
// Latency: n/a (wires only).
// Backpressure: arready/rvalid from the interconnect; the CPU sees addr_ok/data_ok.
//   slave  : cache view (fetch requests in, refill traffic out)
//   master : environment view (fetch stage + AXI bridge)
interface icache_nway_burst_if;
    logic        flush;
    logic        cpu_inst_req;
    logic [31:0] cpu_inst_addr;
    logic [31:0] cpu_inst_rdata;
    logic        cpu_inst_addr_ok;
    logic        cpu_inst_data_ok;

    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  flush, cpu_inst_req, cpu_inst_addr,
        input  arready, rdata, rlast, rvalid,
        output cpu_inst_rdata, cpu_inst_addr_ok, cpu_inst_data_ok,
        output araddr, arlen, arsize, arburst, arvalid, rready
    );

    modport master (
        output flush, cpu_inst_req, cpu_inst_addr,
        output arready, rdata, rlast, rvalid,
        input  cpu_inst_rdata, cpu_inst_addr_ok, cpu_inst_data_ok,
        input  araddr, arlen, arsize, arburst, arvalid, rready
    );

endinterface

// File: rtl/icache_nway_burst_way.sv
// One cache way: valid bits, tag array and line data with combinational read.
// Latency: read is combinational; writes land on the next rising clk.
// Backpressure: none; the parent controller sequences all writes.
//   rd_*     : lookup by index/word, returns hit for rd_tag, valid bit and word
//   wr_*     : single word write at {wr_index, wr_word}
//   tag_we   : write wr_tag at wr_index
//   valid_we : write valid_val at wr_index; clr_all invalidates every set
module icache_nway_burst_way #(
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clr_all,
    input  logic [INDEX_WIDTH-1:0]               rd_index,
    input  logic [OFFSET_WIDTH-3:0]              rd_word,
    input  logic [31-INDEX_WIDTH-OFFSET_WIDTH:0] rd_tag,
    output logic                                 rd_hit,
    output logic                                 rd_valid,
    output logic [31:0]                          rd_data,
    input  logic                                 wr_en,
    input  logic [INDEX_WIDTH-1:0]               wr_index,
    input  logic [OFFSET_WIDTH-3:0]              wr_word,
    input  logic [31:0]                          wr_data,
    input  logic                                 tag_we,
    input  logic [31-INDEX_WIDTH-OFFSET_WIDTH:0] wr_tag,
    input  logic                                 valid_we,
    input  logic                                 valid_val
);
    localparam int CACHE_DEPTH = 2 ** INDEX_WIDTH;
    localparam int WORDS       = 2 ** (OFFSET_WIDTH - 2);
    localparam int TAG_W       = 32 - INDEX_WIDTH - OFFSET_WIDTH;

    logic [CACHE_DEPTH-1:0] valid_q, valid_d;

    // Tag and data storage are plain RAM arrays with no reset; the valid
    // bits alone decide whether their contents mean anything.
    logic [TAG_W-1:0] tag_mem  [CACHE_DEPTH];
    logic [31:0]      data_mem [CACHE_DEPTH*WORDS];

    always_comb begin
        valid_d = valid_q;
        // A global clear wins over a same-cycle set so that a flush that
        // overlaps the end of a refill leaves the new line invalid too.
        if (clr_all) begin
            valid_d = '0;
        end else if (valid_we) begin
            valid_d[wr_index] = valid_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_word}] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_hit   = valid_q[rd_index] && (tag_mem[rd_index] == rd_tag);
    assign rd_data  = data_mem[{rd_index, rd_word}];

endmodule

// File: rtl/icache_nway_burst.sv
// N-way set-associative read-only instruction cache with AXI-like burst refill.
// Latency: hit answers in the request cycle; miss answers on the beat carrying the requested word.
// Backpressure: one outstanding miss; addr_ok is low while a refill is in flight or flush is high.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch port (req/addr/rdata/addr_ok/data_ok, flush) and AR/R refill channel
module icache_nway_burst
    import icache_nway_burst_pkg::*;
#(
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 5,
    parameter int WAY_NUM      = 2
) (
    input  logic               clk,
    input  logic               rst,
    icache_nway_burst_if.slave bus
);
    localparam int CACHE_DEPTH = 2 ** INDEX_WIDTH;
    localparam int WORDS       = 2 ** (OFFSET_WIDTH - 2);
    localparam int WORD_W      = OFFSET_WIDTH - 2;
    localparam int TAG_W       = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int WAY_BITS    = way_bits(WAY_NUM);

    localparam logic [WORD_W-1:0]   CNT_LAST = WORD_W'(WORDS - 1);
    localparam logic [WAY_BITS-1:0] PTR_LAST = WAY_BITS'(WAY_NUM - 1);

    // Request address fields.
    logic [TAG_W-1:0]       req_tag;
    logic [INDEX_WIDTH-1:0] req_index;
    logic [WORD_W-1:0]      req_word;
    logic                   unused_addr_lsb;

    assign req_tag         = bus.cpu_inst_addr[31 -: TAG_W];
    assign req_index       = bus.cpu_inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_word        = bus.cpu_inst_addr[2 +: WORD_W];
    assign unused_addr_lsb = ^bus.cpu_inst_addr[1:0];

    // Controller state and miss latches.
    state_e                 state_q, state_d;
    logic [TAG_W-1:0]       tag_s_q, tag_s_d;
    logic [INDEX_WIDTH-1:0] index_s_q, index_s_d;
    logic [WORD_W-1:0]      word_s_q, word_s_d;
    logic [WAY_BITS-1:0]    victim_q, victim_d;
    logic [WORD_W-1:0]      cnt_q, cnt_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [WAY_BITS-1:0]    victim_ptr_q [CACHE_DEPTH];
    logic [WAY_BITS-1:0]    victim_ptr_d [CACHE_DEPTH];

    // Way lookup results.
    logic [WAY_NUM-1:0] way_hit;
    logic [WAY_NUM-1:0] way_valid;
    logic [31:0]        way_rdata [WAY_NUM];

    logic                hit_any;
    logic [31:0]         hit_data;
    logic                inv_found;
    logic [WAY_BITS-1:0] inv_way;
    logic [WAY_BITS-1:0] victim_sel;

    // Write strobes towards the victim way.
    logic wr_en, tag_we, valid_we, valid_val, clr_all;
    logic flush_seen;

    // Descending scan: the last assignment is the lowest-numbered hitting way.
    always_comb begin
        hit_any  = 1'b0;
        hit_data = '0;
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (way_hit[w]) begin
                hit_any  = 1'b1;
                hit_data = way_rdata[w];
            end
        end
    end

    // Fill an empty way first; only evict in FIFO order when the set is full.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_BITS'(w);
            end
        end
        victim_sel = inv_found ? inv_way : victim_ptr_q[req_index];
    end

    // A flush seen at any point of the refill, including its last beat.
    assign flush_seen = flush_pend_q || bus.flush;

    always_comb begin
        state_d      = state_q;
        tag_s_d      = tag_s_q;
        index_s_d    = index_s_q;
        word_s_d     = word_s_q;
        victim_d     = victim_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        victim_ptr_d = victim_ptr_q;

        bus.cpu_inst_addr_ok = 1'b0;
        bus.cpu_inst_data_ok = 1'b0;
        bus.cpu_inst_rdata   = hit_data;
        bus.arvalid          = 1'b0;
        bus.rready           = 1'b0;

        wr_en     = 1'b0;
        tag_we    = 1'b0;
        valid_we  = 1'b0;
        valid_val = 1'b0;
        clr_all   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Nothing is accepted while reset is held.
                if (!rst) begin
                    if (bus.flush) begin
                        clr_all = 1'b1;
                    end else if (bus.cpu_inst_req) begin
                        bus.cpu_inst_addr_ok = 1'b1;
                        if (hit_any) begin
                            bus.cpu_inst_data_ok = 1'b1;
                        end else begin
                            tag_s_d   = req_tag;
                            index_s_d = req_index;
                            word_s_d  = req_word;
                            victim_d  = victim_sel;
                            cnt_d     = '0;
                            state_d   = ST_AR;
                        end
                    end
                end
            end

            ST_AR: begin
                bus.arvalid = 1'b1;
                if (bus.flush) begin
                    flush_pend_d = 1'b1;
                end
                if (bus.arready) begin
                    state_d = ST_R;
                end
            end

            ST_R: begin
                bus.rready         = 1'b1;
                bus.cpu_inst_rdata = bus.rdata;
                if (bus.flush) begin
                    flush_pend_d = 1'b1;
                end
                if (bus.rvalid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    // Early restart: hand the word to the CPU on its own beat.
                    if (cnt_q == word_s_q) begin
                        bus.cpu_inst_data_ok = 1'b1;
                    end
                    if (bus.rlast) begin
                        tag_we   = 1'b1;
                        valid_we = 1'b1;
                        // A short burst or a flush during the refill leaves
                        // the line invalid; this also drops any stale valid
                        // bit of the evicted line.
                        valid_val    = (cnt_q == CNT_LAST) && !flush_seen;
                        clr_all      = flush_seen;
                        flush_pend_d = 1'b0;
                        cnt_d        = '0;
                        victim_ptr_d[index_s_q] = (victim_ptr_q[index_s_q] == PTR_LAST)
                                                  ? '0
                                                  : victim_ptr_q[index_s_q] + WAY_BITS'(1);
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tag_s_q      <= '0;
            index_s_q    <= '0;
            word_s_q     <= '0;
            victim_q     <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            for (int i = 0; i < CACHE_DEPTH; i++) begin
                victim_ptr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            tag_s_q      <= tag_s_d;
            index_s_q    <= index_s_d;
            word_s_q     <= word_s_d;
            victim_q     <= victim_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            victim_ptr_q <= victim_ptr_d;
        end
    end

    // The interconnect must deliver exactly WORDS beats per burst.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_R && bus.rvalid && bus.rlast) begin
            assert (cnt_q == CNT_LAST);
        end
    end

    // The AR address comes straight from the miss latches, so it cannot
    // move while arvalid waits for arready.
    assign bus.araddr  = {tag_s_q, index_s_q, {OFFSET_WIDTH{1'b0}}};
    assign bus.arlen   = 8'(WORDS - 1);
    assign bus.arsize  = ARSIZE_WORD;
    assign bus.arburst = ARBURST_INCR;

    for (genvar g = 0; g < WAY_NUM; g++) begin : g_way
        logic sel;
        assign sel = (victim_q == WAY_BITS'(g));

        icache_nway_burst_way #(
            .INDEX_WIDTH  (INDEX_WIDTH),
            .OFFSET_WIDTH (OFFSET_WIDTH)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .clr_all   (clr_all),
            .rd_index  (req_index),
            .rd_word   (req_word),
            .rd_tag    (req_tag),
            .rd_hit    (way_hit[g]),
            .rd_valid  (way_valid[g]),
            .rd_data   (way_rdata[g]),
            .wr_en     (wr_en && sel),
            .wr_index  (index_s_q),
            .wr_word   (cnt_q),
            .wr_data   (bus.rdata),
            .tag_we    (tag_we && sel),
            .wr_tag    (tag_s_q),
            .valid_we  (valid_we && sel),
            .valid_val (valid_val)
        );
    end

endmodule

// File: tb/tb_icache_nway_burst.sv
// Bench for icache_nway_burst with default parameters (128 sets, 8-word lines, 2 ways).
// Latency: n/a.
// Backpressure: bench acts as fetch stage and AXI slave with programmable arready delay and rvalid gaps.
module tb_icache_nway_burst;

    localparam int SETS = 128;
    localparam int WAYS = 2;

    logic clk;
    logic rst;

    icache_nway_burst_if bus ();

    icache_nway_burst #(
        .INDEX_WIDTH  (7),
        .OFFSET_WIDTH (5),
        .WAY_NUM      (WAYS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cur_addr = '0;

    // Reference cache contents: per set a valid/tag pair per way and a FIFO pointer.
    bit          mv [SETS][WAYS];
    logic [19:0] mt [SETS][WAYS];
    int          mp [SETS];

    typedef struct {
        logic [31:0] addr;
        bit          exp_hit;
        int          ar_dly;
        logic [7:0]  gaps;
    } vec_t;

    vec_t tbl [19];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s addr=%h: got %b, expected %b", name, cur_addr, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s addr=%h: got %h, expected %h", name, cur_addr, act, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        int s;
        s = int'(a[11:5]);
        for (int w = 0; w < WAYS; w++) begin
            if (mv[s][w] && mt[s][w] == a[31:12]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_clear_valid();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
    endtask

    task automatic model_reset();
        model_clear_valid();
        for (int s = 0; s < SETS; s++) mp[s] = 0;
    endtask

    task automatic model_fill(input logic [31:0] a, input bit flushed);
        int s;
        int v;
        s = int'(a[11:5]);
        v = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (!mv[s][w] && v < 0) v = w;
        end
        if (v < 0) v = mp[s];
        mp[s] = (mp[s] + 1) % WAYS;
        if (flushed) begin
            model_clear_valid();
        end else begin
            mv[s][v] = 1'b1;
            mt[s][v] = a[31:12];
        end
    endtask

    // One fetch: request cycle, then (on a miss) the AR handshake and an
    // 8-beat burst. gaps[i] inserts one idle cycle before beat i;
    // flush_beat >= 0 raises flush during that beat.
    task automatic fetch(input logic [31:0] addr, input bit exp_hit, input int ar_dly,
                         input logic [7:0] gaps, input int flush_beat);
        logic [31:0] line;
        int          off;
        int          beat;
        int          dok;
        bit          gap_done;
        bit          flushed;
        line     = addr & ~32'h1F;
        off      = int'(addr[4:2]);
        cur_addr = addr;
        @(negedge clk);
        bus.cpu_inst_req  = 1'b1;
        bus.cpu_inst_addr = addr;
        #1;
        check1("addr_ok", bus.cpu_inst_addr_ok, 1'b1);
        check1("req_data_ok", bus.cpu_inst_data_ok, exp_hit);
        check1("req_arvalid", bus.arvalid, 1'b0);
        if (exp_hit) check32("hit_rdata", bus.cpu_inst_rdata, mem_word(addr));
        @(negedge clk);
        bus.cpu_inst_req = 1'b0;
        if (!exp_hit) begin
            for (int i = 0; i <= ar_dly; i++) begin
                if (i > 0) @(negedge clk);
                bus.arready = (i == ar_dly);
                #1;
                check1("ar_arvalid", bus.arvalid, 1'b1);
                check32("ar_araddr", bus.araddr, line);
                check1("ar_addr_ok", bus.cpu_inst_addr_ok, 1'b0);
            end
            check32("arlen", 32'(bus.arlen), 32'd7);
            check32("arsize_arburst", {27'd0, bus.arsize, bus.arburst}, {27'd0, 3'b010, 2'b01});
            @(negedge clk);
            bus.arready = 1'b0;
            beat     = 0;
            dok      = 0;
            gap_done = 1'b0;
            flushed  = 1'b0;
            while (beat < 8) begin
                bus.flush = (beat == flush_beat);
                if (beat == flush_beat) flushed = 1'b1;
                if (gaps[beat] && !gap_done) begin
                    bus.rvalid = 1'b0;
                    bus.rlast  = 1'b0;
                    bus.rdata  = 32'hDEAD_BEEF;
                    gap_done   = 1'b1;
                end else begin
                    bus.rvalid = 1'b1;
                    bus.rlast  = (beat == 7);
                    bus.rdata  = mem_word(line + 32'(4 * beat));
                    gap_done   = 1'b0;
                end
                #1;
                check1("r_rready", bus.rready, 1'b1);
                check1("r_data_ok", bus.cpu_inst_data_ok, bus.rvalid && (beat == off));
                if (bus.cpu_inst_data_ok) begin
                    dok++;
                    check32("r_rdata", bus.cpu_inst_rdata, mem_word(addr));
                end
                if (bus.rvalid) beat++;
                @(negedge clk);
            end
            bus.rvalid = 1'b0;
            bus.rlast  = 1'b0;
            bus.flush  = 1'b0;
            #1;
            check1("end_rready", bus.rready, 1'b0);
            check1("end_arvalid", bus.arvalid, 1'b0);
            check1("end_no_data_ok", bus.cpu_inst_data_ok, 1'b0);
            check32("data_ok_pulses", 32'(dok), 32'd1);
            model_fill(addr, flushed);
        end
    endtask

    // Flush while idle with a request pending: the request must not be taken.
    task automatic flush_idle(input logic [31:0] addr);
        cur_addr = addr;
        @(negedge clk);
        bus.flush         = 1'b1;
        bus.cpu_inst_req  = 1'b1;
        bus.cpu_inst_addr = addr;
        #1;
        check1("flush_addr_ok", bus.cpu_inst_addr_ok, 1'b0);
        check1("flush_data_ok", bus.cpu_inst_data_ok, 1'b0);
        @(negedge clk);
        bus.flush        = 1'b0;
        bus.cpu_inst_req = 1'b0;
        model_clear_valid();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        // Expected hit/miss follows from the FIFO fill order of set 0:
        // 0x1000 sits in way0 after test 1 with the pointer at way1.
        tbl[0]  = '{32'h0000_1000, 1'b1, 0, 8'h00};
        tbl[1]  = '{32'h0000_1004, 1'b1, 0, 8'h00};
        tbl[2]  = '{32'h0000_1008, 1'b1, 0, 8'h00};
        tbl[3]  = '{32'h0000_100C, 1'b1, 0, 8'h00};
        tbl[4]  = '{32'h0000_1010, 1'b1, 0, 8'h00};
        tbl[5]  = '{32'h0000_1014, 1'b1, 0, 8'h00};
        tbl[6]  = '{32'h0000_1018, 1'b1, 0, 8'h00};
        tbl[7]  = '{32'h0000_101C, 1'b1, 0, 8'h00};
        tbl[8]  = '{32'h0000_2000, 1'b0, 1, 8'h05};  // fills way1
        tbl[9]  = '{32'h0000_3008, 1'b0, 0, 8'h80};  // evicts way0 (0x1000)
        tbl[10] = '{32'h0000_2004, 1'b1, 0, 8'h00};
        tbl[11] = '{32'h0000_300C, 1'b1, 0, 8'h00};
        tbl[12] = '{32'h0000_1000, 1'b0, 2, 8'h00};  // evicts way1 (0x2000)
        tbl[13] = '{32'h0000_2000, 1'b0, 0, 8'h10};  // evicts way0 (0x3000)
        tbl[14] = '{32'h0000_1010, 1'b1, 0, 8'h00};
        tbl[15] = '{32'h0000_1020, 1'b0, 0, 8'hFF};  // set 1
        tbl[16] = '{32'h0000_1024, 1'b1, 0, 8'h00};
        tbl[17] = '{32'h0000_3000, 1'b0, 1, 8'h00};  // evicts way1 (0x1000)
        tbl[18] = '{32'h0000_2018, 1'b1, 0, 8'h00};

        rst               = 1'b1;
        bus.flush         = 1'b0;
        bus.cpu_inst_req  = 1'b1;
        bus.cpu_inst_addr = 32'h0000_1000;
        bus.arready       = 1'b0;
        bus.rdata         = '0;
        bus.rlast         = 1'b0;
        bus.rvalid        = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        #1;
        check1("rst_addr_ok", bus.cpu_inst_addr_ok, 1'b0);
        check1("rst_data_ok", bus.cpu_inst_data_ok, 1'b0);
        check1("rst_arvalid", bus.arvalid, 1'b0);
        check1("rst_rready", bus.rready, 1'b0);
        check32("rst_araddr", bus.araddr, 32'h0);
        @(negedge clk);
        bus.cpu_inst_req = 1'b0;
        rst = 1'b0;

        // Cold miss, word 1, arready after 3 cycles.
        fetch(32'h0000_1004, 1'b0, 3, 8'h00, -1);

        // Table: refetch of the line, then set-0 eviction order.
        for (int i = 0; i < 19; i++) begin
            fetch(tbl[i].addr, tbl[i].exp_hit, tbl[i].ar_dly, tbl[i].gaps, -1);
        end

        // Flush during the refill of 0x4000: word still delivered, then all miss.
        fetch(32'h0000_4000, 1'b0, 1, 8'h00, 3);
        fetch(32'h0000_4000, 1'b0, 0, 8'h00, -1);
        fetch(32'h0000_2000, 1'b0, 0, 8'h00, -1);
        fetch(32'h0000_3000, 1'b0, 0, 8'h00, -1);
        fetch(32'h0000_1024, 1'b0, 0, 8'h00, -1);

        // Idle flush: request held off, previously resident line misses after.
        fetch(32'h0000_1028, 1'b1, 0, 8'h00, -1);
        flush_idle(32'h0000_1028);
        fetch(32'h0000_1028, 1'b0, 0, 8'h02, -1);

        // Reset while AR is pending.
        cur_addr = 32'h0000_1000;
        @(negedge clk);
        bus.cpu_inst_req  = 1'b1;
        bus.cpu_inst_addr = 32'h0000_1000;
        #1;
        check1("t5_miss", bus.cpu_inst_data_ok, 1'b0);
        @(negedge clk);
        bus.cpu_inst_req = 1'b0;
        #1;
        check1("t5_arvalid_before", bus.arvalid, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check1("t5_arvalid_after", bus.arvalid, 1'b0);
        check1("t5_rready_after", bus.rready, 1'b0);
        model_reset();
        fetch(32'h0000_1000, 1'b0, 0, 8'h00, -1);
        fetch(32'h0000_1000, 1'b1, 0, 8'h00, -1);

        // Last word of the line with rvalid gaps: data_ok lands on rlast.
        fetch(32'h0000_501C, 1'b0, 4, 8'hAA, -1);

        // Random traffic over a few tags and sets against the reference model.
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            int          r;
            int          fb;
            a = (32'($urandom_range(1, 5)) << 12) |
                (32'($urandom_range(0, 3)) << 5)  |
                (32'($urandom_range(0, 7)) << 2);
            r  = int'($urandom_range(0, 19));
            fb = (r == 1) ? int'($urandom_range(0, 7)) : -1;
            if (r == 0) flush_idle(a);
            fetch(a, model_hit(a), int'($urandom_range(0, 2)), 8'($urandom), fb);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
